mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter.sv | 102 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Four-source round-robin arbiter feeding a one-word registered output buffer.
// Define MUX_ARB_LOCK_EN to let a locked requester keep the grant across words.
module mux_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  input  logic       lock,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] grant,
  output logic [3:0] ack
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0] r_state;
  logic [7:0] r_out_data;
  logic [1:0] r_grant;
  logic [3:0] r_ack;
  logic [1:0] r_last;

  logic [7:0] w_src [4];
  logic [1:0] w_cand [4];
  logic       w_rr_found;
  logic [1:0] w_rr_idx;
  logic       w_accept;
  logic       w_do_grant;
  logic       w_lock_hit;
  logic [1:0] w_sel;

  assign w_src[0] = a;
  assign w_src[1] = b;
  assign w_src[2] = c;
  assign w_src[3] = d;

  // Candidate k is the source k+1 places after the last winner, wrapping mod 4.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign w_cand[gi] = r_last + 2'(gi + 1);
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest active one wins.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[w_cand[k]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand[k];
      end
    end
  end

`ifdef MUX_ARB_LOCK_EN
  assign w_lock_hit = (r_state == ST_HOLD) && out_ready && lock && req[r_grant];
`else
  logic w_unused_lock;
  assign w_unused_lock = lock;
  assign w_lock_hit    = 1'b0;
`endif

  // The buffer can take a new word when empty or when its word leaves this cycle.
  assign w_accept   = (r_state == ST_IDLE) || out_ready;
  assign w_do_grant = w_accept && w_rr_found;
  assign w_sel      = w_lock_hit ? r_grant : w_rr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_out_data <= 8'h00;
      r_grant    <= 2'b00;
      r_ack      <= 4'b0000;
      r_last     <= 2'd3;
    end else begin
      r_ack <= 4'b0000;
      if (w_do_grant) begin
        r_state    <= ST_HOLD;
        r_out_data <= w_src[w_sel];
        r_grant    <= w_sel;
        r_ack      <= 4'b0001 << w_sel;
        if (!w_lock_hit) begin
          r_last <= w_sel;
        end
      end else if (w_accept) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign out_valid = (r_state == ST_HOLD);
  assign out_data  = r_out_data;
  assign grant     = r_grant;
  assign ack       = r_ack;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, hand-written
// reset/lock sequences, then random traffic against a behavioural model.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] a, b, c, d;
  logic       lock;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] grant;
  logic [3:0] ack;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [3:0] req;
    logic [7:0] dd;
    logic       rdy;
    logic       ev;
    logic [7:0] edata;
    logic [1:0] eg;
    logic [3:0] eack;
  } vec_t;

  vec_t tbl [19];
  int   lock_exp [5];

  int         m_last;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_grant;
  logic [3:0] m_ack;
  logic [7:0] src [4];

  mux_rr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .lock(lock), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data),
    .grant(grant), .ack(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed,
                         input logic [1:0] eg, input logic [3:0] ea);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".out_data"},  32'(out_data),  32'(ed));
    chk({tag, ".grant"},     32'(grant),     32'(eg));
    chk({tag, ".ack"},       32'(ack),       32'(ea));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'h0; lock = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; req = 4'h0; lock = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h01; c = 8'h02; d = 8'h03;

    // round-robin sweep, held word, wrap, idle, IDLE grant without ready, single requester
    tbl[0]  = '{4'b1111, 8'h03, 1'b1, 1'b1, 8'h00, 2'd0, 4'b0001};
    tbl[1]  = '{4'b1111, 8'h03, 1'b1, 1'b1, 8'h01, 2'd1, 4'b0010};
    tbl[2]  = '{4'b1111, 8'h03, 1'b1, 1'b1, 8'h02, 2'd2, 4'b0100};
    tbl[3]  = '{4'b1111, 8'h03, 1'b1, 1'b1, 8'h03, 2'd3, 4'b1000};
    tbl[4]  = '{4'b1111, 8'h03, 1'b1, 1'b1, 8'h00, 2'd0, 4'b0001};
    tbl[5]  = '{4'b0100, 8'h03, 1'b1, 1'b1, 8'h02, 2'd2, 4'b0100};
    tbl[6]  = '{4'b0100, 8'h03, 1'b0, 1'b1, 8'h02, 2'd2, 4'b0000};
    tbl[7]  = '{4'b0100, 8'h03, 1'b0, 1'b1, 8'h02, 2'd2, 4'b0000};
    tbl[8]  = '{4'b0100, 8'h03, 1'b0, 1'b1, 8'h02, 2'd2, 4'b0000};
    tbl[9]  = '{4'b0100, 8'h03, 1'b0, 1'b1, 8'h02, 2'd2, 4'b0000};
    tbl[10] = '{4'b0100, 8'h03, 1'b0, 1'b1, 8'h02, 2'd2, 4'b0000};
    tbl[11] = '{4'b0010, 8'h03, 1'b1, 1'b1, 8'h01, 2'd1, 4'b0010};
    tbl[12] = '{4'b0011, 8'h03, 1'b1, 1'b1, 8'h00, 2'd0, 4'b0001};
    tbl[13] = '{4'b0000, 8'h03, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
    tbl[14] = '{4'b0000, 8'h03, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000};
    tbl[15] = '{4'b1000, 8'h03, 1'b0, 1'b1, 8'h03, 2'd3, 4'b1000};
    tbl[16] = '{4'b1000, 8'h55, 1'b0, 1'b1, 8'h03, 2'd3, 4'b0000};
    tbl[17] = '{4'b1000, 8'h55, 1'b1, 1'b1, 8'h55, 2'd3, 4'b1000};
    tbl[18] = '{4'b0000, 8'h55, 1'b1, 1'b0, 8'h55, 2'd3, 4'b0000};

`ifdef MUX_ARB_LOCK_EN
    lock_exp = '{1, 1, 1, 1, 3};
`else
    lock_exp = '{1, 3, 1, 3, 1};
`endif

    @(posedge clk); #1;
    chk_out("reset", 1'b0, 8'h00, 2'd0, 4'b0000);
    $display("reset: valid=%b data=%h grant=%0d ack=%b", out_valid, out_data, grant, ack);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      req = tbl[i].req; d = tbl[i].dd; out_ready = tbl[i].rdy;
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].edata, tbl[i].eg, tbl[i].eack);
      $display("vec %0d: req=%b rdy=%b -> valid=%b data=%h grant=%0d ack=%b",
               i, tbl[i].req, tbl[i].rdy, out_valid, out_data, grant, ack);
    end

    // asynchronous reset while a word is held
    d = 8'h03; req = 4'b1000; out_ready = 1'b0;
    @(posedge clk); #1;
    chk_out("hold_before_rst", 1'b1, 8'h03, 2'd3, 4'b1000);
    req = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 8'h00, 2'd0, 4'b0000);
    $display("async reset mid-hold: valid=%b data=%h grant=%0d ack=%b", out_valid, out_data, grant, ack);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_out($sformatf("post_rst%0d", i), 1'b0, 8'h00, 2'd0, 4'b0000);
      $display("post-reset cycle %0d: valid=%b ack=%b", i, out_valid, ack);
    end

    // lock sequence: req=1010, lock raised after the first grant of source 1
    do_reset();
    b = 8'h11; d = 8'h33; req = 4'b1010; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lock = (i >= 1 && i <= 3);
      @(posedge clk); #1;
      chk($sformatf("lock%0d.grant", i), 32'(grant), 32'(lock_exp[i]));
      chk($sformatf("lock%0d.ack", i), 32'(ack), 32'(4'b0001 << lock_exp[i]));
      $display("lock step %0d: lock=%b -> grant=%0d ack=%b", i, lock, grant, ack);
    end

    // random traffic against the behavioural model
    do_reset();
    m_last = 3; m_valid = 0; m_data = 8'h00; m_grant = 0; m_ack = 4'h0;
    for (int t = 0; t < 300; t++) begin
      logic [3:0] rq;
      logic       rdy, lk;
      int         sel;
      rq  = ($urandom % 5 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rdy = ($urandom % 4 != 0);
      lk  = 1'($urandom % 2);
      for (int s = 0; s < 4; s++) src[s] = 8'($urandom);
      req = rq; out_ready = rdy; lock = lk;
      a = src[0]; b = src[1]; c = src[2]; d = src[3];

      if ((!m_valid || rdy) && rq != 4'h0) begin
        sel = -1;
`ifdef MUX_ARB_LOCK_EN
        if (m_valid && rdy && lk && rq[m_grant]) sel = m_grant;
`endif
        if (sel < 0) begin
          for (int k = 1; k <= 4; k++)
            if (sel < 0 && rq[(m_last + k) % 4]) sel = (m_last + k) % 4;
          m_last = sel;
        end
        m_valid = 1; m_data = src[sel]; m_grant = sel; m_ack = 4'b0001 << sel;
      end else begin
        m_ack = 4'h0;
        if (!m_valid || rdy) m_valid = 0;
      end

      @(posedge clk); #1;
      chk_out($sformatf("rnd%0d", t), m_valid, m_data, 2'(m_grant), m_ack);
      $display("rnd %0d: req=%b rdy=%b lock=%b -> valid=%b data=%h grant=%0d ack=%b",
               t, rq, rdy, lk, out_valid, out_data, grant, ack);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
